// File: rtl/approx_mult_pkg.sv
// rtl/approx_mult_pkg.sv - shared constants and state type for the approximate-multiplier error monitor
package approx_mult_pkg;
   localparam int W_DEF     = 16;
   localparam int FRAC_DEF  = 16;
   localparam int CNT_W_DEF = 17;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      DIVIDE = 2'd2,
      DONE   = 2'd3
   } state_t;
endpackage

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - restoring serial divider, one quotient bit per cycle, fixed DW-cycle latency
// done_o and quotient_o are valid together in the last busy cycle (quotient includes that cycle's bit).
module serial_divider #(
   parameter int DW = 32,
   parameter int VW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          start_i,
   input  logic [DW-1:0] dividend_i,
   input  logic [VW-1:0] divisor_i,
   output logic          done_o,
   output logic [DW-1:0] quotient_o
);
   localparam int CW = $clog2(DW);
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   logic          busy_q, busy_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] dq_q, dq_d;
   logic [VW-1:0] rem_q, rem_d;
   logic [VW-1:0] dvs_q, dvs_d;
   logic [VW:0]   trial;
   logic          ge;

   // Dividend bits leave dq_q at the top while quotient bits enter at the bottom.
   always_comb begin
      trial  = {rem_q, dq_q[DW-1]};
      ge     = (trial >= {1'b0, dvs_q});
      busy_d = busy_q;
      cnt_d  = cnt_q;
      dq_d   = dq_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      if (clr_i) begin
         busy_d = 1'b0;
      end else if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         dq_d   = dividend_i;
         rem_d  = '0;
         dvs_d  = divisor_i;
      end else if (busy_q) begin
         rem_d = ge ? VW'(trial - {1'b0, dvs_q}) : trial[VW-1:0];
         dq_d  = {dq_q[DW-2:0], ge};
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         dq_q   <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         dq_q   <= dq_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
      end
   end

   assign done_o     = busy_q && (cnt_q == LAST);
   assign quotient_o = {dq_q[DW-2:0], ge};
endmodule

// File: rtl/approx_mult_error_monitor.sv
// rtl/approx_mult_error_monitor.sv - accumulates ER/MED/NED/MRED numerators over (exact, approximate) product pairs
module approx_mult_error_monitor
   import approx_mult_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int FRAC  = FRAC_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_last,
   input  logic [W-1:0]              exact,
   input  logic [W-1:0]              apprx,
   output logic [CNT_W-1:0]          err_count,
   output logic [CNT_W-1:0]          sample_count,
   output logic signed [W+CNT_W:0]   sum_ed,
   output logic [W+CNT_W-1:0]        sum_ed_abs,
   output logic [W-1:0]              max_ed,
   output logic [W+FRAC+CNT_W-1:0]   sum_re,
   output logic                      busy,
   output logic                      done
);
   localparam int SEW = W + CNT_W + 1;
   localparam int SAW = W + CNT_W;
   localparam int SRW = W + FRAC + CNT_W;

   state_t state_q, state_d;

   logic [CNT_W-1:0]    smp_q, smp_d, err_q, err_d;
   logic signed [SEW-1:0] sed_q, sed_d;
   logic [SAW-1:0]      sabs_q, sabs_d;
   logic [W-1:0]        max_q, max_d;
   logic [SRW-1:0]      sre_q, sre_d;
   logic                last_q, last_d;

   logic                xfer, need_div, div_fin, div_done;
   logic signed [W:0]   ed;
   logic [W-1:0]        abs_ed;
   logic [W+FRAC-1:0]   quot;

   assign xfer     = (state_q == ACCEPT) && in_valid;
   assign ed       = $signed({1'b0, exact}) - $signed({1'b0, apprx});
   assign abs_ed   = (exact >= apprx) ? (exact - apprx) : (apprx - exact);
   assign need_div = (exact != '0) && (abs_ed != '0);
   assign div_fin  = (state_q == DIVIDE) && div_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ACCEPT;
         ACCEPT: begin
            if (start) state_d = ACCEPT;
            else if (xfer && need_div) state_d = DIVIDE;
            else if (xfer && in_last) state_d = DONE;
         end
         DIVIDE: begin
            if (start) state_d = ACCEPT;
            else if (div_done) state_d = last_q ? DONE : ACCEPT;
         end
         DONE:    if (start) state_d = ACCEPT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == ACCEPT);
      busy     = (state_q == ACCEPT) || (state_q == DIVIDE);
      done     = (state_q == DONE);
   end

   // start wins over a same-cycle transfer, so that sample never reaches the accumulators.
   always_comb begin
      smp_d  = smp_q;
      err_d  = err_q;
      sed_d  = sed_q;
      sabs_d = sabs_q;
      max_d  = max_q;
      sre_d  = sre_q;
      last_d = last_q;
      if (start) begin
         smp_d  = '0;
         err_d  = '0;
         sed_d  = '0;
         sabs_d = '0;
         max_d  = '0;
         sre_d  = '0;
         last_d = 1'b0;
      end else begin
         if (xfer) begin
            smp_d  = smp_q + 1'b1;
            err_d  = err_q + {{(CNT_W-1){1'b0}}, (abs_ed != '0)};
            sed_d  = sed_q + SEW'(ed);
            sabs_d = sabs_q + SAW'(abs_ed);
            if (abs_ed > max_q) max_d = abs_ed;
            last_d = in_last;
         end
         if (div_fin) begin
            sre_d = sre_q + SRW'(quot);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         smp_q  <= '0;
         err_q  <= '0;
         sed_q  <= '0;
         sabs_q <= '0;
         max_q  <= '0;
         sre_q  <= '0;
         last_q <= 1'b0;
      end else begin
         smp_q  <= smp_d;
         err_q  <= err_d;
         sed_q  <= sed_d;
         sabs_q <= sabs_d;
         max_q  <= max_d;
         sre_q  <= sre_d;
         last_q <= last_d;
      end
   end

   serial_divider #(
      .DW (W + FRAC),
      .VW (W)
   ) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (start),
      .start_i    (xfer && need_div && !start),
      .dividend_i ({abs_ed, {FRAC{1'b0}}}),
      .divisor_i  (exact),
      .done_o     (div_done),
      .quotient_o (quot)
   );

   assign err_count    = err_q;
   assign sample_count = smp_q;
   assign sum_ed       = sed_q;
   assign sum_ed_abs   = sabs_q;
   assign max_ed       = max_q;
   assign sum_re       = sre_q;
endmodule
